// File: rtl/matrix_sequencer.sv
// Stream front/back end for the 4x4 matrix ALU: it collects a command and its operands,
// runs one ALU evaluation, then streams the 16 result words back out.
module matrix_sequencer #(
    parameter int WORD_W = 16,
    parameter int ELEMS  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WORD_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WORD_W-1:0]         out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic [WORD_W*ELEMS-1:0]   alu_a,
    output logic [WORD_W*ELEMS-1:0]   alu_b,
    output logic [3:0]                alu_op,
    input  logic [WORD_W*ELEMS-1:0]   alu_c
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;

    logic [2:0]                state;
    logic [3:0]                cnt;
    logic [3:0]                op;
    logic [WORD_W*ELEMS-1:0]   mat_a;
    logic [WORD_W*ELEMS-1:0]   mat_b;
    logic [WORD_W*ELEMS-1:0]   result;
    logic                      drain_valid;
    logic                      in_xfer;
    logic                      out_xfer;

    function automatic logic is_unary(input logic [3:0] code);
        return (code == 4'd5) || (code == 4'd9) || (code == 4'd10) ||
               (code == 4'd11) || (code == 4'd12);
    endfunction

    assign in_ready  = (state == S_IDLE) || (state == S_LOAD_A) || (state == S_LOAD_B);
    assign in_xfer   = in_valid && in_ready;
    assign out_valid = drain_valid;
    assign out_xfer  = drain_valid && out_ready;
    assign out_last  = drain_valid && (cnt == 4'hF);
    assign out_data  = drain_valid ? result[cnt*WORD_W +: WORD_W] : '0;
    assign busy      = (state != S_IDLE);
    assign alu_a     = mat_a;
    assign alu_b     = mat_b;
    assign alu_op    = op;

    // The first DRAIN cycle only lets the freshly captured result settle; words are
    // offered from the second DRAIN cycle on, two edges after the last operand.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            op          <= '0;
            mat_a       <= '0;
            mat_b       <= '0;
            result      <= '0;
            drain_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    drain_valid <= 1'b0;
                    if (in_xfer) begin
                        op    <= in_data[3:0];
                        mat_a <= '0;
                        mat_b <= '0;
                        cnt   <= '0;
                        state <= S_LOAD_A;
                    end
                end
                S_LOAD_A: begin
                    if (in_xfer) begin
                        mat_a[cnt*WORD_W +: WORD_W] <= in_data;
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'hF) begin
                            state <= is_unary(op) ? S_EXEC : S_LOAD_B;
                        end
                    end
                end
                S_LOAD_B: begin
                    if (in_xfer) begin
                        mat_b[cnt*WORD_W +: WORD_W] <= in_data;
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'hF) begin
                            state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    result      <= alu_c;
                    drain_valid <= 1'b0;
                    state       <= S_DRAIN;
                end
                S_DRAIN: begin
                    drain_valid <= 1'b1;
                    if (out_xfer) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'hF) begin
                            drain_valid <= 1'b0;
                            state       <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    cnt         <= '0;
                    drain_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_sequencer.sv
// Directed bench for matrix_sequencer with a behavioural ALU (add, sub, transpose, xor)
// on the matrix side and immediate-assertion checks at every comparison point.
module tb_matrix_sequencer;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [15:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic         out_last;
    logic         busy;
    logic [255:0] alu_a;
    logic [255:0] alu_b;
    logic [3:0]   alu_op;
    logic [255:0] alu_c;

    int checks_total  = 0;
    int checks_passed = 0;

    matrix_sequencer #(.WORD_W(16), .ELEMS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_c     (alu_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: 3 = add, 4 = subtract, 5 = transpose, anything else = xor.
    always_comb begin
        alu_c = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                case (alu_op)
                    4'd3:    alu_c[(i*4+j)*16 +: 16] = alu_a[(i*4+j)*16 +: 16] + alu_b[(i*4+j)*16 +: 16];
                    4'd4:    alu_c[(i*4+j)*16 +: 16] = alu_a[(i*4+j)*16 +: 16] - alu_b[(i*4+j)*16 +: 16];
                    4'd5:    alu_c[(i*4+j)*16 +: 16] = alu_a[(j*4+i)*16 +: 16];
                    default: alu_c[(i*4+j)*16 +: 16] = alu_a[(i*4+j)*16 +: 16] ^ alu_b[(i*4+j)*16 +: 16];
                endcase
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks_total++;
        assert (observed === expected) checks_passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Presents one input word after an optional idle gap and waits for its handshake.
    task automatic applyStimulus(input logic [15:0] word, input int gap);
        int guard;
        in_valid = 1'b0;
        in_data  = 16'hDEAD;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        in_data  = word;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) checkOutput("in_timeout", 256'(guard), 256'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic load_job(input logic [15:0] cmd, input logic [255:0] a, input logic [255:0] b,
                            input bit unary, input bit gaps);
        applyStimulus(cmd, 0);
        for (int k = 0; k < 16; k++) applyStimulus(a[k*16 +: 16], gaps ? int'($urandom_range(0, 2)) : 0);
        if (!unary) begin
            for (int k = 0; k < 16; k++) applyStimulus(b[k*16 +: 16], gaps ? int'($urandom_range(0, 2)) : 0);
        end
    endtask

    // Collects 16 words with out_ready high; drops in_valid ahead of the final transfer.
    task automatic drain_all(output logic [255:0] data, output logic [15:0] lasts);
        int n;
        int guard;
        n = 0; guard = 0; data = '0; lasts = '0;
        out_ready = 1'b1;
        while (n < 16 && guard < 200) begin
            if (out_valid) begin
                data[n*16 +: 16] = out_data;
                lasts[n] = out_last;
                if (out_last) in_valid = 1'b0;
                n++;
            end
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b0;
        if (n < 16) checkOutput("drain_timeout", 256'(n), 256'(16));
    endtask

    logic [255:0] mat_a_v, mat_b_v, exp_v, got_v;
    logic [15:0]  lasts_v;
    int           n, guard;

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_in_ready",  256'(in_ready),  256'(1));
        checkOutput("rst_busy",      256'(busy),      256'(0));
        checkOutput("rst_out_valid", 256'(out_valid), 256'(0));
        checkOutput("rst_out_last",  256'(out_last),  256'(0));
        checkOutput("rst_out_data",  256'(out_data),  256'(0));
        checkOutput("rst_alu_a",     alu_a,           256'(0));
        checkOutput("rst_alu_b",     alu_b,           256'(0));
        checkOutput("rst_alu_op",    256'(alu_op),    256'(0));
        rst = 1'b1;
        @(posedge clk); #1;

        // MADD with a 5-cycle stall at word 6, then out_ready toggling
        $display("[TB] MADD with backpressure");
        for (int k = 0; k < 16; k++) begin
            mat_a_v[k*16 +: 16] = 16'(k);
            mat_b_v[k*16 +: 16] = 16'h0100 + 16'(k);
            exp_v[k*16 +: 16]   = 16'h0100 + 16'(2*k);
        end
        load_job(16'h0003, mat_a_v, mat_b_v, 1'b0, 1'b0);
        got_v = '0; lasts_v = '0; n = 0; guard = 0;
        out_ready = 1'b1;
        while (n < 6 && guard < 50) begin
            if (out_valid) begin
                got_v[n*16 +: 16] = out_data; lasts_v[n] = out_last; n++;
            end
            @(posedge clk); #1;
            guard++;
        end
        out_ready = 1'b0;
        repeat (5) begin
            checkOutput("stall_data",  256'(out_data),  256'(16'h010C));
            checkOutput("stall_valid", 256'(out_valid), 256'(1));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        guard = 0;
        while (n < 16 && guard < 200) begin
            if (out_ready && out_valid) begin
                got_v[n*16 +: 16] = out_data; lasts_v[n] = out_last; n++;
            end
            @(posedge clk); #1;
            out_ready = ~out_ready;
            guard++;
        end
        out_ready = 1'b0;
        checkOutput("madd_data",     got_v,            exp_v);
        checkOutput("madd_last",     256'(lasts_v),    256'(16'h8000));
        checkOutput("madd_busy_end", 256'(busy),       256'(0));
        checkOutput("madd_ready_end",256'(in_ready),   256'(1));

        // MSUB: command upper bits ignored, two-cycle latency, 0 - 1 wraps
        $display("[TB] MSUB latency");
        load_job(16'hABC4, 256'(0), {16{16'h0001}}, 1'b0, 1'b0);
        checkOutput("msub_op",      256'(alu_op),    256'(4));
        checkOutput("msub_lat0",    256'(out_valid), 256'(0));
        checkOutput("msub_exec_rdy",256'(in_ready),  256'(0));
        @(posedge clk); #1;
        checkOutput("msub_lat1",    256'(out_valid), 256'(0));
        @(posedge clk); #1;
        checkOutput("msub_lat2",    256'(out_valid), 256'(1));
        drain_all(got_v, lasts_v);
        checkOutput("msub_data",    got_v,           {16{16'hFFFF}});

        // MTRANS: unary, 17 input transfers total
        $display("[TB] MTRANS");
        applyStimulus(16'h0005, 0);
        for (int k = 0; k < 15; k++) applyStimulus(16'(k), 0);
        checkOutput("mtrans_rdy16", 256'(in_ready), 256'(1));
        applyStimulus(16'd15, 0);
        checkOutput("mtrans_rdy17", 256'(in_ready), 256'(0));
        exp_v = {16'd15, 16'd11, 16'd7, 16'd3, 16'd14, 16'd10, 16'd6, 16'd2,
                 16'd13, 16'd9,  16'd5, 16'd1, 16'd12, 16'd8,  16'd4, 16'd0};
        drain_all(got_v, lasts_v);
        checkOutput("mtrans_data",  got_v,          exp_v);
        checkOutput("mtrans_b",     alu_b,          256'(0));

        // Input gaps during load, in_valid held high with junk through EXEC and DRAIN
        $display("[TB] input gaps");
        for (int k = 0; k < 16; k++) begin
            mat_a_v[k*16 +: 16] = 16'(k) * 16'h1111;
            mat_b_v[k*16 +: 16] = 16'h00FF;
            exp_v[k*16 +: 16]   = (16'(k) * 16'h1111) ^ 16'h00FF;
        end
        load_job(16'h0001, mat_a_v, mat_b_v, 1'b0, 1'b1);
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        checkOutput("gap_exec_rdy", 256'(in_ready), 256'(0));
        drain_all(got_v, lasts_v);
        in_valid = 1'b0;
        checkOutput("gap_data",     got_v,          exp_v);
        checkOutput("gap_alu_a",    alu_a,          mat_a_v);
        checkOutput("gap_alu_b",    alu_b,          mat_b_v);
        checkOutput("gap_idle",     256'(busy),     256'(0));

        // Reset after 7 B words, then a clean MADD
        $display("[TB] reset mid LOAD_B");
        applyStimulus(16'h0003, 0);
        for (int k = 0; k < 16; k++) applyStimulus(16'h0010 + 16'(k), 0);
        for (int k = 0; k < 7; k++)  applyStimulus(16'h0020 + 16'(k), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checkOutput("mid_rst_alu_a",    alu_a,           256'(0));
        checkOutput("mid_rst_alu_b",    alu_b,           256'(0));
        checkOutput("mid_rst_in_ready", 256'(in_ready),  256'(1));
        checkOutput("mid_rst_busy",     256'(busy),      256'(0));
        checkOutput("mid_rst_alu_op",   256'(alu_op),    256'(0));
        checkOutput("mid_rst_out_valid",256'(out_valid), 256'(0));
        for (int k = 0; k < 16; k++) begin
            mat_a_v[k*16 +: 16] = 16'(k);
            mat_b_v[k*16 +: 16] = 16'h0100 + 16'(k);
            exp_v[k*16 +: 16]   = 16'h0100 + 16'(2*k);
        end
        load_job(16'h0003, mat_a_v, mat_b_v, 1'b0, 1'b0);
        drain_all(got_v, lasts_v);
        checkOutput("post_rst_data", got_v,          exp_v);
        checkOutput("post_rst_last", 256'(lasts_v),  256'(16'h8000));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/matrix_sequencer.md
# matrix_sequencer

Stream-to-matrix front/back end for the 4x4 16-bit matrix ALU. It accepts a command word plus 16 or 32 operand words over a valid/ready input stream and assembles them into the 256-bit A and B operands. It drives the ALU for one evaluation cycle and captures the 256-bit result. It then returns the 16 result words over a valid/ready output stream.

## Interface
Parameters:
- WORD_W, 16, element width; fixed to match the ALU lane width.
- ELEMS, 16, elements per matrix; fixed to 4x4, row-major.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  input word valid.
- in_ready  out  1  sequencer can accept an input word.
- in_data  in  16  command or operand word.
- out_valid  out  1  result word valid.
- out_ready  in  1  consumer accepts result word.
- out_data  out  16  result word.
- out_last  out  1  marks the 16th result word.
- busy  out  1  high whenever state is not IDLE.
- alu_a  out  256  to ALU matrix_a; element (i,j) at bits [(i*4+j)*16 +: 16].
- alu_b  out  256  to ALU matrix_b; same packing as alu_a.
- alu_op  out  4  to ALU op.
- alu_c  in  256  from ALU matrix_c; same packing as alu_a.

## Operation
- Input transfer: in_valid && in_ready on a rising edge. Output transfer: out_valid && out_ready on a rising edge.
- States:
  - IDLE: accepts the command word. in_data[3:0] is latched into the op register; in_data[15:4] is ignored. A and B are cleared to 0, the counter is cleared, and the state goes to LOAD_A.
  - LOAD_A: each accepted word is written to A element cnt, and cnt increments. On the transfer with cnt==15, cnt wraps to 0. If op is unary, the next state is EXEC; otherwise it is LOAD_B.
    - Unary ops: 5, 9, 10, 11, 12.
    - Binary ops: all other op values, including 0.
  - LOAD_B: same as LOAD_A, writing B. After the transfer with cnt==15, the next state is EXEC. For unary ops B stays 0.
  - EXEC: one cycle. alu_a, alu_b and alu_op are stable, and the ALU output is combinational. At the end of this cycle alu_c is registered into the result register, and the state goes to DRAIN.
  - DRAIN: out_data is result element cnt. Each output transfer increments cnt. After the transfer with cnt==15, cnt goes to 0 and the state goes to IDLE.
- Output decode:
  - alu_a, alu_b and alu_op are driven directly from the A, B and op registers.
  - alu_op holds its value from command acceptance until the next command.
- The block does no arithmetic; result bits come unmodified from the ALU, truncated to 16 bits by the ALU.

## Timing
- Reset (rst sampled low) forces the following, effective the cycle after that edge:
  - State IDLE, cnt 0.
  - A, B, result and op registers all 0.
  - out_valid 0, out_last 0, out_data 0, busy 0, in_ready 1, alu_op 0.
- Reset has priority over every transfer in the same cycle. Reset mid-operation discards partial operands and any undelivered results.
- in_ready = 1 in IDLE, LOAD_A and LOAD_B; 0 in EXEC and DRAIN. It is decoded from registered state, with no combinational path from in_valid.
- out_valid = 1 only in DRAIN. out_last = 1 only in DRAIN with cnt==15.
- Latency: last operand accepted at edge T. EXEC occupies cycle T..T+1. out_valid is first high after edge T+2, carrying word 0.
- While out_valid && !out_ready, out_data and out_last hold stable, and no word is skipped or repeated.
- After the last output transfer, in_ready is 1 the following cycle; there is no overlap between jobs.
- Gaps in in_valid or out_ready stall only; only completed transfers advance cnt.

## Test plan
- MADD:
  - Stimulus: command 0x0003; A words k = 0..15 with value k; B words with value 0x0100+k.
  - Response: output words 0x0100+2k for k = 0..15; out_last only on the 16th word; busy falls the cycle after it.
- MTRANS:
  - Stimulus: command 0x0005; 16 A words with value k.
  - Response: in_ready drops after exactly 17 input transfers; outputs 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15.
- Command decode, latency and wrap:
  - Stimulus: command 0xABC4 (MSUB); all A = 0x0000; all B = 0x0001.
  - Response: alu_op = 4; out_valid rises exactly 2 cycles after the last B transfer; all outputs 0xFFFF.
- Backpressure:
  - Stimulus: during MADD drain, hold out_ready low for 5 cycles at word 6, then toggle it every cycle.
  - Response: out_data holds 0x010C while stalled; all 16 words delivered in order, exactly once.
- Input gaps:
  - Stimulus: deassert in_valid pseudo-randomly during LOAD_A and LOAD_B; assert in_valid during EXEC and DRAIN.
  - Response: only handshaken words are stored; no words are accepted during EXEC or DRAIN; results match the reference model.
- Reset mid-LOAD_B:
  - Stimulus: after 7 B words, drive rst low for 1 cycle.
  - Response: all outputs take their reset values (alu_a and alu_b 0, in_ready 1). A following full MADD job then completes correctly.
